// File: rtl/stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: stop bus encodings,
// divider sequencer states and the divider result bus type.
package stall_ctrl_pkg;

  typedef logic [5:0]  stop_all_bus_t;
  typedef logic [63:0] div_result_bus_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // Bit order {rsvd, MEM/WB, EX/MEM, ID/EX, IF/ID, PC}
  localparam stop_all_bus_t STOP_EX   = {NO_STOP, NO_STOP, STOP, STOP, STOP, STOP};
  localparam stop_all_bus_t STOP_ID   = {NO_STOP, NO_STOP, NO_STOP, STOP, STOP, STOP};
  localparam stop_all_bus_t STOP_NONE = {6{NO_STOP}};

endpackage

// File: rtl/stall_if.sv
// Stall request / divider handshake bundle between the pipeline and stall_ctrl.
interface stall_if;
  import stall_ctrl_pkg::*;

  logic            id_stop_request;
  logic            ex_stop_request;
  logic            ex_div_start;
  logic            ex_div_annul;
  logic            div_ready_input;
  div_result_bus_t div_result_input;
  stop_all_bus_t   stop_all;
  logic            div_start_output;
  div_result_bus_t div_result_output;
  logic            div_result_valid;
  logic            div_timeout_output;

  modport master (
    output id_stop_request, ex_stop_request, ex_div_start, ex_div_annul,
           div_ready_input, div_result_input,
    input  stop_all, div_start_output, div_result_output, div_result_valid,
           div_timeout_output
  );

  modport slave (
    input  id_stop_request, ex_stop_request, ex_div_start, ex_div_annul,
           div_ready_input, div_result_input,
    output stop_all, div_start_output, div_result_output, div_result_valid,
           div_timeout_output
  );

endinterface

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: merges ID/EX stall requests into stop_all and
// sequences the multi-cycle divider (launch, hold EX, latch result, watchdog).
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MAX_DIV_CYCLES = 40,
  parameter int PERF_WIDTH     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  stall_if.slave                bus,
  output logic [PERF_WIDTH-1:0] stall_cycle_count
);

  localparam int CNT_W = $clog2(MAX_DIV_CYCLES + 1);

  div_state_e      state, state_next;
  logic [CNT_W-1:0] busy_cnt, busy_cnt_inc;
  logic            latch_result;
  logic            timeout_next;
  logic            timeout;
  logic            ex_stall;
  div_result_bus_t result;
  logic [PERF_WIDTH-1:0] perf_cnt;

  assign busy_cnt_inc = busy_cnt + CNT_W'(1);

  // Annul beats ready, ready beats the watchdog.
  always_comb begin
    state_next   = state;
    latch_result = 1'b0;
    timeout_next = 1'b0;
    unique case (state)
      DIV_IDLE: begin
        if (bus.ex_div_start && !bus.ex_div_annul) state_next = DIV_BUSY;
      end
      DIV_BUSY: begin
        if (bus.ex_div_annul) begin
          state_next = DIV_IDLE;
        end else if (bus.div_ready_input) begin
          state_next   = DIV_DONE;
          latch_result = 1'b1;
        end else if (busy_cnt_inc == CNT_W'(MAX_DIV_CYCLES)) begin
          state_next   = DIV_IDLE;
          timeout_next = 1'b1;
        end
      end
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  always_comb begin
    ex_stall = (state == DIV_BUSY) || bus.ex_stop_request ||
               ((state == DIV_IDLE) && bus.ex_div_start && !bus.ex_div_annul);
    if (ex_stall)                 bus.stop_all = STOP_EX;
    else if (bus.id_stop_request) bus.stop_all = STOP_ID;
    else                          bus.stop_all = STOP_NONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= DIV_IDLE;
      busy_cnt <= '0;
      timeout  <= 1'b0;
      result   <= '0;
      perf_cnt <= '0;
    end else begin
      state   <= state_next;
      timeout <= timeout_next;
      if (state != DIV_BUSY)
        busy_cnt <= '0;
      else
        busy_cnt <= busy_cnt_inc;
      if (latch_result)
        result <= bus.div_result_input;
      if (bus.stop_all[0] == STOP && perf_cnt != {PERF_WIDTH{1'b1}})
        perf_cnt <= perf_cnt + PERF_WIDTH'(1);
    end
  end

  assign bus.div_start_output   = (state == DIV_BUSY);
  assign bus.div_result_valid   = (state == DIV_DONE);
  assign bus.div_result_output  = result;
  assign bus.div_timeout_output = timeout;
  assign stall_cycle_count      = perf_cnt;

endmodule
